// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// Both the top FSM and the word assembler import these.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] DEF_MAGIC = 8'hA5;

  // Width of the byte position inside a 32-bit payload word.
  localparam int BIDX_W = 2;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs payload bytes into little-endian 32-bit words and keeps a mod-256
// running sum. word_ready pulses for one cycle after the 4th byte of a word.
import prog_loader_pkg::*;

module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  data,
  input  logic        strobe,
  output logic [31:0] word,
  output logic        word_ready,
  output logic        last,
  output logic [7:0]  csum
);

  logic [BIDX_W-1:0] idx;
  logic [23:0]       acc;

  assign last = (idx == BIDX_W'(3));

  // The finished word is held in its own register, so a byte accepted in
  // the strobe cycle can start the next word without disturbing it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx        <= '0;
      acc        <= '0;
      csum       <= '0;
      word       <= '0;
      word_ready <= 1'b0;
    end else if (clear) begin
      idx        <= '0;
      acc        <= '0;
      csum       <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      if (strobe) begin
        csum <= csum + data;
        idx  <= idx + BIDX_W'(1);
        if (last) begin
          word       <= {data, acc};
          word_ready <= 1'b1;
        end else begin
          acc[{idx, 3'b000} +: 8] <= data;
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: MAGIC, count, payload, checksum. Writes words
// through the CPU's external-write port and releases cpu_hold on success.
import prog_loader_pkg::*;

module prog_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MEM_WORDS      = 64,
  parameter logic [7:0]  MAGIC          = DEF_MAGIC,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        restart,
  output logic        cpu_hold,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] words_loaded
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] MAX_N    = 16'(MEM_WORDS);

  state_t      state, state_nx;
  logic [15:0] n_q;
  logic [31:0] tcnt;
  logic        accept, counting, timed_out, byte_stb, asm_clear, last_word;
  logic [15:0] n_full;
  logic        word_ready, last;
  logic [31:0] word;
  logic [7:0]  csum;

  assign rx_ready  = reset && (state inside {IDLE, CNT_LO, CNT_HI, DATA, CSUM});
  assign accept    = rx_valid && rx_ready;
  assign counting  = state inside {CNT_LO, CNT_HI, DATA, CSUM};
  assign timed_out = counting && !accept && (tcnt == TMO_LAST);
  assign n_full    = {rx_data, n_q[7:0]};
  assign last_word = (words_loaded == n_q - 16'd1);
  assign byte_stb  = accept && (state == DATA) && !restart;
  assign asm_clear = restart || (accept && (state == CNT_HI));

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .data       (rx_data),
    .strobe     (byte_stb),
    .word       (word),
    .word_ready (word_ready),
    .last       (last),
    .csum       (csum)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (accept && rx_data == MAGIC) state_nx = CNT_LO;
      CNT_LO: if (accept) state_nx = CNT_HI;
      CNT_HI:
        if (accept) begin
          if (n_full > MAX_N)       state_nx = ERR;
          else if (n_full == 16'd0) state_nx = CSUM;
          else                      state_nx = DATA;
        end
      DATA:   if (accept && last && last_word) state_nx = CSUM;
      CSUM:   if (accept) state_nx = (rx_data == csum) ? DONE : ERR;
      default: ;
    endcase
    if (timed_out) state_nx = ERR;
    // restart wins over any byte accepted in the same cycle
    if (restart)   state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      n_q          <= '0;
      tcnt         <= '0;
      words_loaded <= '0;
      Ext_DataAdr  <= '0;
    end else begin
      state <= state_nx;
      if (restart) begin
        n_q          <= '0;
        tcnt         <= '0;
        words_loaded <= '0;
      end else begin
        tcnt <= (accept || !counting) ? '0 : tcnt + 32'd1;
        if (accept && state == CNT_LO) n_q[7:0] <= rx_data;
        if (accept && state == CNT_HI) begin
          n_q[15:8]    <= rx_data;
          words_loaded <= '0;
        end else if (word_ready) begin
          words_loaded <= words_loaded + 16'd1;
        end
        // Address is captured with the 4th byte so it lines up with the strobe.
        if (byte_stb && last)
          Ext_DataAdr <= BASE_ADDR + {14'b0, words_loaded, 2'b00};
      end
    end
  end

  assign Ext_MemWrite  = word_ready;
  assign Ext_WriteData = word;
  assign cpu_hold      = (state != DONE);
  assign load_done     = (state == DONE);
  assign load_error    = (state == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framed loads, checksum/size errors,
// timeout with restart, and reset landing on the 4th payload byte.
module tb_prog_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        restart = 1'b0;
  logic        rx_ready, cpu_hold, Ext_MemWrite, load_done, load_error;
  logic [31:0] Ext_WriteData, Ext_DataAdr;
  logic [15:0] words_loaded;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] wr_adr[$];
  logic [31:0] wr_dat[$];

  prog_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .restart(restart), .cpu_hold(cpu_hold),
    .Ext_MemWrite(Ext_MemWrite), .Ext_WriteData(Ext_WriteData),
    .Ext_DataAdr(Ext_DataAdr), .load_done(load_done), .load_error(load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (Ext_MemWrite) begin
      wr_adr.push_back(Ext_DataAdr);
      wr_dat.push_back(Ext_WriteData);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; rx_valid = 1'b0; restart = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wr_adr.delete(); wr_dat.delete();
  endtask

  task automatic send(input bq_t q);
    foreach (q[i]) begin
      @(negedge clk);
      rx_data = q[i]; rx_valid = 1'b1;
    end
  endtask

  task automatic stop_rx();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    n_cmp++; if ({cpu_hold, rx_ready, Ext_MemWrite, load_done, load_error} !== 5'b10000) begin
      n_err++; $display("FAIL reset_flags: got %b want 10000", {cpu_hold, rx_ready, Ext_MemWrite, load_done, load_error}); end
    n_cmp++; if ({Ext_WriteData, Ext_DataAdr, words_loaded} !== 80'h0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", {Ext_WriteData, Ext_DataAdr, words_loaded}); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (rx_ready !== 1'b1) begin
      n_err++; $display("FAIL idle_ready: got %b want 1", rx_ready); end
  endtask

  task automatic test_two_words(input logic [7:0] cs, input logic good);
    do_reset();
    send('{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, cs});
    n_cmp++; if (cpu_hold !== 1'b1) begin
      n_err++; $display("FAIL hold_before_csum: got %b want 1", cpu_hold); end
    stop_rx();
    n_cmp++; if (wr_adr.size() !== 2) begin
      n_err++; $display("FAIL two_words_count: got %0d want 2", wr_adr.size()); end
    else begin
      n_cmp++; if ({wr_adr[0], wr_dat[0]} !== 64'h00000000_00500093) begin
        n_err++; $display("FAIL word0: got %h want 0000000000500093", {wr_adr[0], wr_dat[0]}); end
      n_cmp++; if ({wr_adr[1], wr_dat[1]} !== 64'h00000004_00100113) begin
        n_err++; $display("FAIL word1: got %h want 0000000400100113", {wr_adr[1], wr_dat[1]}); end
    end
    n_cmp++; if (words_loaded !== 16'd2) begin
      n_err++; $display("FAIL two_words_loaded: got %0d want 2", words_loaded); end
    if (good) begin
      n_cmp++; if ({load_done, load_error, cpu_hold, rx_ready} !== 4'b1000) begin
        n_err++; $display("FAIL good_csum_status: got %b want 1000", {load_done, load_error, cpu_hold, rx_ready}); end
    end else begin
      n_cmp++; if ({load_done, load_error, cpu_hold, rx_ready} !== 4'b0110) begin
        n_err++; $display("FAIL bad_csum_status: got %b want 0110", {load_done, load_error, cpu_hold, rx_ready}); end
    end
  endtask

  task automatic test_leading_junk();
    do_reset();
    send('{8'h00, 8'h3C, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38});
    stop_rx();
    n_cmp++; if (wr_adr.size() !== 1) begin
      n_err++; $display("FAIL junk_count: got %0d want 1", wr_adr.size()); end
    else begin
      n_cmp++; if ({wr_adr[0], wr_dat[0]} !== 64'h00000000_DEADBEEF) begin
        n_err++; $display("FAIL junk_word: got %h want 00000000DEADBEEF", {wr_adr[0], wr_dat[0]}); end
    end
    n_cmp++; if ({load_done, load_error, cpu_hold} !== 3'b100) begin
      n_err++; $display("FAIL junk_status: got %b want 100", {load_done, load_error, cpu_hold}); end
  endtask

  task automatic test_too_big();
    do_reset();
    send('{8'hA5, 8'h41, 8'h00});
    stop_rx();
    repeat (3) @(negedge clk);
    n_cmp++; if ({load_error, load_done, cpu_hold, rx_ready} !== 4'b1010) begin
      n_err++; $display("FAIL too_big_status: got %b want 1010", {load_error, load_done, cpu_hold, rx_ready}); end
    n_cmp++; if (wr_adr.size() !== 0) begin
      n_err++; $display("FAIL too_big_writes: got %0d want 0", wr_adr.size()); end
  endtask

  task automatic test_zero_words();
    do_reset();
    send('{8'hA5, 8'h00, 8'h00, 8'h00});
    stop_rx();
    n_cmp++; if ({load_done, load_error, cpu_hold, words_loaded} !== {3'b100, 16'd0}) begin
      n_err++; $display("FAIL zero_status: got %h want %h", {load_done, load_error, cpu_hold, words_loaded}, {3'b100, 16'd0}); end
    n_cmp++; if (wr_adr.size() !== 0) begin
      n_err++; $display("FAIL zero_writes: got %0d want 0", wr_adr.size()); end
  endtask

  task automatic test_timeout_restart();
    do_reset();
    send('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22});
    stop_rx();
    repeat (15) @(negedge clk);
    n_cmp++; if (load_error !== 1'b0) begin
      n_err++; $display("FAIL timeout_early: got %b want 0", load_error); end
    @(negedge clk);
    n_cmp++; if ({load_error, cpu_hold, rx_ready} !== 3'b110) begin
      n_err++; $display("FAIL timeout_err: got %b want 110", {load_error, cpu_hold, rx_ready}); end
    n_cmp++; if (wr_adr.size() !== 0) begin
      n_err++; $display("FAIL timeout_writes: got %0d want 0", wr_adr.size()); end
    restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    n_cmp++; if ({load_error, load_done, cpu_hold, rx_ready, words_loaded} !== {4'b0011, 16'd0}) begin
      n_err++; $display("FAIL restart_state: got %h want %h", {load_error, load_done, cpu_hold, rx_ready, words_loaded}, {4'b0011, 16'd0}); end
  endtask

  task automatic test_done_restart_then_reset_midframe();
    test_leading_junk();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    n_cmp++; if ({cpu_hold, load_done, rx_ready} !== 3'b101) begin
      n_err++; $display("FAIL done_restart: got %b want 101", {cpu_hold, load_done, rx_ready}); end
    wr_adr.delete(); wr_dat.delete();
    send('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
    reset = 1'b0;
    #1;
    n_cmp++; if ({cpu_hold, rx_ready, Ext_MemWrite, load_done, load_error, words_loaded} !== {5'b10000, 16'd0}) begin
      n_err++; $display("FAIL async_flags: got %h want %h", {cpu_hold, rx_ready, Ext_MemWrite, load_done, load_error, words_loaded}, {5'b10000, 16'd0}); end
    n_cmp++; if ({Ext_WriteData, Ext_DataAdr} !== 64'h0) begin
      n_err++; $display("FAIL async_data: got %h want 0", {Ext_WriteData, Ext_DataAdr}); end
    @(negedge clk); rx_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (wr_adr.size() !== 0) begin
      n_err++; $display("FAIL midframe_writes: got %0d want 0", wr_adr.size()); end
  endtask

  initial begin
    test_reset();
    test_two_words(8'h07, 1'b1);
    test_two_words(8'h08, 1'b0);
    test_too_big();
    test_zero_words();
    test_timeout_restart();
    test_done_restart_then_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
